// File: rtl/write_buffer.sv
// write_buffer: holds dirty cachelines evicted from the data RAM until main memory
// accepts them. Circular FIFO with same-line coalescing, a two-state valid/ready
// drain FSM, and a combinational lookup port that forwards buffered data to refills.
module write_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHELINE_WIDTH = 128,
  parameter int OFFSET_WIDTH    = 4,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // push side (data RAM eviction)
  input  logic                       write_buffer_en,
  input  logic [ADDR_WIDTH-1:0]      addr_to_write_buffer,
  input  logic [CACHELINE_WIDTH-1:0] data_to_write_buffer,
  output logic                       wb_full,
  output logic                       wb_empty,
  output logic                       wb_overflow,
  // drain side (main-memory write port)
  output logic                       mem_wr_valid,
  output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  output logic [CACHELINE_WIDTH-1:0] mem_wr_data,
  input  logic                       mem_wr_ready,
  // load-miss forwarding
  input  logic [ADDR_WIDTH-1:0]      lookup_addr,
  output logic                       lookup_hit,
  output logic [CACHELINE_WIDTH-1:0] lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state_reg, state_next;
  logic [PTR_W-1:0]           head_reg, tail_reg;
  logic [CNT_W-1:0]           count_reg, count_next;
  logic [DEPTH-1:0]           valid_reg;
  logic                       full_reg, empty_reg, overflow_reg;

  // Entry storage; contents are qualified by valid_reg, so never reset.
  logic [ADDR_WIDTH-1:0]      addr_mem [DEPTH];
  logic [CACHELINE_WIDTH-1:0] data_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]      push_line;
  logic [ADDR_WIDTH-1:0]      look_line;
  logic [DEPTH-1:0]           push_match;
  logic [DEPTH-1:0]           look_match;
  logic [PTR_W-1:0]           age_idx [DEPTH];

  logic                       coal_hit;
  logic [PTR_W-1:0]           coal_idx;
  logic                       look_hit;
  logic [PTR_W-1:0]           look_idx;

  logic                       pop;
  logic                       push_coal;
  logic                       push_alloc;
  logic                       push_drop;

  assign push_line = addr_to_write_buffer & LINE_MASK;
  assign look_line = lookup_addr & LINE_MASK;

  // Per-entry line comparators. The head is excluded from coalescing only while
  // it is being transferred, so data already presented to memory never changes.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign push_match[gi] = valid_reg[gi] && (addr_mem[gi] == push_line) &&
                              !((state_reg == SEND) && (head_reg == PTR_W'(gi)));
      assign look_match[gi] = valid_reg[gi] && (addr_mem[gi] == look_line);
      // age_idx[0] is the oldest entry, age_idx[DEPTH-1] the youngest slot.
      assign age_idx[gi]    = head_reg + PTR_W'(gi);
    end
  endgenerate

  // Youngest-match select: walk from head towards tail, later matches win.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    look_hit = 1'b0;
    look_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (push_match[age_idx[k]]) begin
        coal_hit = 1'b1;
        coal_idx = age_idx[k];
      end
      if (look_match[age_idx[k]]) begin
        look_hit = 1'b1;
        look_idx = age_idx[k];
      end
    end
  end

  // Push/pop decode. Full uses the registered (pre-edge) count, so a push at
  // full is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    pop        = (state_reg == SEND) && mem_wr_ready;
    push_coal  = write_buffer_en && coal_hit;
    push_alloc = write_buffer_en && !coal_hit && !full_reg;
    push_drop  = write_buffer_en && !coal_hit && full_reg;
  end

  // Occupancy after this edge.
  always_comb begin
    count_next = count_reg;
    if (push_alloc && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push_alloc && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Entry data/address writes: allocation at tail or in-place coalesce.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      addr_mem[tail_reg] <= push_line;
      data_mem[tail_reg] <= data_to_write_buffer;
    end else if (push_coal) begin
      data_mem[coal_idx] <= data_to_write_buffer;
    end
  end

  // Pointers, occupancy, valid bits and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      valid_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (pop) begin
        head_reg            <= head_reg + PTR_W'(1);
        valid_reg[head_reg] <= 1'b0;
      end
      if (push_alloc) begin
        tail_reg            <= tail_reg + PTR_W'(1);
        valid_reg[tail_reg] <= 1'b1;
      end
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Drain FSM next-state: start once anything is buffered, stop when the
  // last entry has been accepted and nothing new was allocated.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = SEND;
      SEND:    if (pop && (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain FSM outputs: head entry presented only while sending, zero otherwise.
  always_comb begin
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    if (state_reg == SEND) begin
      mem_wr_valid = 1'b1;
      mem_wr_addr  = addr_mem[head_reg];
      mem_wr_data  = data_mem[head_reg];
    end
  end

  // Forwarding and status outputs.
  always_comb begin
    lookup_hit  = look_hit;
    lookup_data = look_hit ? data_mem[look_idx] : '0;
    wb_full     = full_reg;
    wb_empty    = empty_reg;
    wb_overflow = overflow_reg;
  end

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: scoreboard bench for write_buffer. Expected write-backs are
// queued as pushes are driven and popped/compared at each handshake.
module tb_write_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         write_buffer_en = 1'b0;
  logic [31:0]  addr_to_write_buffer = '0;
  logic [127:0] data_to_write_buffer = '0;
  logic         wb_full, wb_empty, wb_overflow;
  logic         mem_wr_valid;
  logic [31:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         mem_wr_ready = 1'b0;
  logic [31:0]  lookup_addr = '0;
  logic         lookup_hit;
  logic [127:0] lookup_data;

  ent_t exp_q[$];
  bit   model_send;
  bit   model_ovf;
  int   n_checks = 0;
  int   n_errors = 0;

  write_buffer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .write_buffer_en      (write_buffer_en),
    .addr_to_write_buffer (addr_to_write_buffer),
    .data_to_write_buffer (data_to_write_buffer),
    .wb_full              (wb_full),
    .wb_empty             (wb_empty),
    .wb_overflow          (wb_overflow),
    .mem_wr_valid         (mem_wr_valid),
    .mem_wr_addr          (mem_wr_addr),
    .mem_wr_data          (mem_wr_data),
    .mem_wr_ready         (mem_wr_ready),
    .lookup_addr          (lookup_addr),
    .lookup_hit           (lookup_hit),
    .lookup_data          (lookup_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check status against the model, score any handshake, advance model, clock once.
  task automatic tick();
    bit pop;
    int ci;
    int presize;
    ent_t e;
    #2;
    chk("valid", mem_wr_valid, model_send);
    chk("full", wb_full, exp_q.size() == DEPTH);
    chk("empty", wb_empty, exp_q.size() == 0);
    chk("overflow", wb_overflow, model_ovf);
    if (!model_send && exp_q.size() == 0) begin
      chk("idle_addr", mem_wr_addr, 0);
      chk("idle_data", mem_wr_data, 0);
    end
    pop = model_send && mem_wr_ready;
    if (pop) begin
      chk("wr_addr", mem_wr_addr, exp_q[0].addr);
      chk("wr_data", mem_wr_data, exp_q[0].data);
      $display("WB addr=%h data=%h", mem_wr_addr, mem_wr_data);
    end
    presize = exp_q.size();
    if (write_buffer_en) begin
      ci = -1;
      for (int i = 0; i < presize; i++) begin
        if (!(model_send && i == 0) && exp_q[i].addr == line_of(addr_to_write_buffer)) ci = i;
      end
      if (ci >= 0) begin
        exp_q[ci].data = data_to_write_buffer;
      end else if (presize < DEPTH) begin
        e.addr = line_of(addr_to_write_buffer);
        e.data = data_to_write_buffer;
        exp_q.push_back(e);
      end else begin
        model_ovf = 1'b1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (!model_send) model_send = (presize != 0);
    else if (pop && exp_q.size() == 0) model_send = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [127:0] d);
    write_buffer_en      = 1'b1;
    addr_to_write_buffer = a;
    data_to_write_buffer = d;
    tick();
    write_buffer_en      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic look(input logic [31:0] a);
    logic         hit;
    logic [127:0] d;
    lookup_addr = a;
    #1;
    hit = 1'b0;
    d   = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].addr == line_of(a)) begin
        hit = 1'b1;
        d   = exp_q[i].data;
      end
    end
    chk("lk_hit", lookup_hit, hit);
    chk("lk_data", lookup_data, d);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    write_buffer_en = 1'b0;
    mem_wr_ready    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    model_send = 1'b0;
    model_ovf  = 1'b0;
  endtask

  logic [127:0] d0, d1, d2, d3, d4;
  logic [31:0]  lines [5];

  initial begin
    lines[0] = 32'h100; lines[1] = 32'h140; lines[2] = 32'h180;
    lines[3] = 32'h1C0; lines[4] = 32'h200;
    d0 = rnd128(); d1 = rnd128(); d2 = rnd128(); d3 = rnd128(); d4 = rnd128();

    // Reset state.
    do_reset();
    look(32'h0);
    idle(1);

    // Single push held off by ready=0, then one transfer.
    push(32'h0000_1234, d0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      chk("hold_addr", mem_wr_addr, 32'h0000_1230);
      chk("hold_data", mem_wr_data, d0);
      tick();
    end
    mem_wr_ready = 1'b1;
    idle(3);

    // Fill to full, overflow on the 5th, drain back-to-back.
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h1000 * (i + 1), rnd128());
    idle(1);
    mem_wr_ready = 1'b1;
    idle(6);

    // Same line as the in-flight head allocates a new entry.
    mem_wr_ready = 1'b0;
    push(32'h40, d1);
    push(32'h80, rnd128());
    push(32'h44, d2);
    look(32'h48);
    look(32'h80);
    mem_wr_ready = 1'b1;
    idle(5);

    // Coalesce behind an in-flight head.
    mem_wr_ready = 1'b0;
    push(32'h300, rnd128());
    push(32'h100, d3);
    push(32'h10C, d4);
    look(32'h100);
    idle(1);
    mem_wr_ready = 1'b1;
    idle(4);

    // Push at full with a simultaneous pop is dropped; push+pop at count 2.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'h40 * i, rnd128());
    idle(1);
    mem_wr_ready = 1'b1;
    push(32'h9000, rnd128());
    mem_wr_ready = 1'b0;
    idle(1);
    mem_wr_ready = 1'b1;
    idle(2);
    mem_wr_ready = 1'b0;
    idle(1);
    push(32'hA000, rnd128());
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(32'hB000 + 32'h40 * i, rnd128());
    idle(5);

    // Random mix: coalescing, wrap, stalls and lookups.
    for (int i = 0; i < 80; i++) begin
      mem_wr_ready = ($urandom_range(0, 2) != 0);
      look(lines[$urandom_range(0, 4)] + 32'($urandom_range(0, 15)));
      write_buffer_en      = ($urandom_range(0, 1) == 1);
      addr_to_write_buffer = lines[$urandom_range(0, 4)] + 32'($urandom_range(0, 15));
      data_to_write_buffer = rnd128();
      tick();
    end
    write_buffer_en = 1'b0;
    mem_wr_ready    = 1'b1;
    idle(8);

    // Reset while a transfer is pending discards everything.
    mem_wr_ready = 1'b0;
    push(32'h700, rnd128());
    push(32'h740, rnd128());
    idle(1);
    do_reset();
    look(32'h700);
    look(32'h740);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
